mem_port_arbiter: RTL

//  Shares one single-port sp_mem between the core instruction-fetch port and the data port.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/resp_tag_pipe.sv | 31 +++
 rtl/mem_port_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Owner tags, default parameters and the streak counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_INSTR = 2'd1,
        OWNER_DATA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic        ena;
        logic        read;
        logic [29:0] addr;
        logic [3:0]  wsel;
        logic [31:0] wdata;
    } mem_cmd_t;

    localparam int unsigned DEF_RD_LATENCY      = 1;
    localparam int unsigned DEF_MAX_DATA_STREAK = 4;

    function automatic int unsigned streak_width(input int unsigned max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/resp_tag_pipe.sv
// Delay line of owner tags matching the memory read latency.
// Asynchronous clear drops every in-flight response.
module resp_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_RD_LATENCY
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag,
    output owner_t head
);

    owner_t stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= OWNER_NONE;
            end
        end else begin
            stage[0] <= tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign head = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data ports.
// Data has priority; a streak limit guarantees fetch progress.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY      = DEF_RD_LATENCY,
    parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_ena_o,
    output logic        mem_read_o,
    output logic [29:0] mem_addr_o,
    output logic [3:0]  mem_wsel_byte_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned SW = streak_width(MAX_DATA_STREAK);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt;
    logic          instr_win;
    logic          data_win;
    mem_cmd_t      cmd;
    owner_t        push_tag;
    owner_t        head_tag;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^{instr_addr_i[1:0], data_addr_i[1:0]};

    // Grants are masked while reset is held so every output reads 0.
    always_comb begin
        instr_win = 1'b0;
        data_win  = 1'b0;
        if (rstn_i) begin
            if (instr_req_i && data_req_i) begin
                if (streak == STREAK_MAX) begin
                    instr_win = 1'b1;
                end else begin
                    data_win = 1'b1;
                end
            end else if (instr_req_i) begin
                instr_win = 1'b1;
            end else if (data_req_i) begin
                data_win = 1'b1;
            end
        end
    end

    always_comb begin
        streak_nxt = streak;
        if (!instr_req_i || instr_win) begin
            streak_nxt = '0;
        end else if (data_win && (streak != STREAK_MAX)) begin
            streak_nxt = streak + SW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            streak <= '0;
        end else begin
            streak <= streak_nxt;
        end
    end

    always_comb begin
        cmd      = '0;
        push_tag = OWNER_NONE;
        unique case (1'b1)
            instr_win: begin
                cmd.ena  = 1'b1;
                cmd.read = 1'b1;
                cmd.addr = instr_addr_i[31:2];
                push_tag = OWNER_INSTR;
            end
            data_win: begin
                cmd.ena   = 1'b1;
                cmd.read  = !data_we_i;
                cmd.addr  = data_addr_i[31:2];
                cmd.wsel  = data_we_i ? data_be_i : 4'b0000;
                cmd.wdata = data_wdata_i;
                push_tag  = data_we_i ? OWNER_NONE : OWNER_DATA;
            end
            default: ;
        endcase
    end

    resp_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk   (clk_i),
        .rst_n (rstn_i),
        .tag   (push_tag),
        .head  (head_tag)
    );

    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = '0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = '0;
        unique case (head_tag)
            OWNER_INSTR: begin
                instr_rvalid_o = 1'b1;
                instr_rdata_o  = mem_rdata_i;
            end
            OWNER_DATA: begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = mem_rdata_i;
            end
            default: ;
        endcase
    end

    assign instr_gnt_o     = instr_win;
    assign data_gnt_o      = data_win;
    assign mem_ena_o       = cmd.ena;
    assign mem_read_o      = cmd.read;
    assign mem_addr_o      = cmd.addr;
    assign mem_wsel_byte_o = cmd.wsel;
    assign mem_wdata_o     = cmd.wdata;

endmodule
